muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the 5-stage pipeline, placed in EX alongside the ALU.
- Executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the HI/LO architectural registers.
- Provides a busy/done handshake so the hazard logic can stall IF/ID/EX while an operation runs.
- Also services MTHI/MTLO writes and a pipeline flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; legal values are even and ≥ 4.
- CNT_W, $clog2(WIDTH), width of the step counter (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- data1_i  in  WIDTH  rs value (multiplicand / dividend).
- data2_i  in  WIDTH  rt value (multiplier / divisor).
- flush_i  in  1  abort the in-flight operation.
- wr_hi_i  in  1  MTHI write strobe.
- wr_lo_i  in  1  MTLO write strobe.
- wr_data_i  in  WIDTH  MTHI/MTLO data.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse: HI/LO just updated by an operation.
- div_zero_o  out  1  qualifies done_o; the completed divide had divisor 0.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; hi_o, lo_o, counter and internal datapath cleared to 0; busy_o, done_o, div_zero_o = 0. A reset mid-operation discards it silently.
- States: IDLE, RUN, FIN. busy_o is registered and equals (state != IDLE).
- IDLE, start_i=1 and flush_i=0 at edge E0:
  - capture op_i;
  - capture |data1_i| and |data2_i| for signed ops, raw values for unsigned ops;
  - record the result signs;
  - counter = WIDTH-1; go to RUN.
- RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per edge; E1..EWIDTH. At the edge where counter==0, go to FIN. Otherwise decrement the counter.
- FIN, edge E(WIDTH+1):
  - Multiply: apply sign fix (negate the 2·WIDTH product if operand signs differ), then HI = upper half, LO = lower half.
  - Divide: LO = quotient, negated if signs differ. HI = remainder, taking the dividend's sign.
  - Then go to IDLE and pulse done_o=1 for exactly the following cycle.
  - Latency: done_o is high in the cycle after edge E(WIDTH+1), i.e. edge 33 for WIDTH=32. busy_o is high for WIDTH+1 cycles.
- Divide by zero:
  - No early exit; the full latency still applies.
  - Result: HI = dividend (unmodified input value), LO = all ones.
  - div_zero_o = 1 coincident with done_o; otherwise div_zero_o = 0.
- Signed overflow (DIV of INT_MIN by -1): LO = INT_MIN, HI = 0. No flag.
- start_i while busy (RUN/FIN) is ignored and not queued. A start_i in the same cycle as done_o is accepted, since state is IDLE.
- flush_i=1 in RUN or FIN: go to IDLE at the next edge. HI/LO are unchanged, and no done_o is produced. A flush in IDLE blocks a simultaneous start_i. Flush has priority over FIN completion.
- wr_hi_i / wr_lo_i:
  - In IDLE, the selected register(s) load wr_data_i at the edge. Both strobes together load both registers.
  - While busy they are ignored (the pipeline guarantees a stall).
  - If asserted together with an accepted start_i, the write occurs and the operation later overwrites it.
- Outputs hi_o and lo_o are registered and change only at FIN, on an MTHI/MTLO write, or on reset.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum {IDLE, RUN, FIN};
  - a function for two's-complement absolute value.
- One natural sub-module, muldiv_step: combinational, WIDTH-parametrised, computing one multiply or divide iteration from (acc, operand, op_is_div). It is instantiated once.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 -> busy_o for 33 cycles; done_o in cycle after E33; HI=0xFFFFFFFE, LO=0x00000001, div_zero_o=0.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF; div_zero_o=1 together with done_o at cycle 33.
- Preload HI/LO = 0xAAAA/0x5555 via MTHI/MTLO, start MULT, flush_i at cycle 10 -> busy_o low next cycle, HI/LO unchanged, no done_o. A start_i at cycle 5 of a running op is ignored (result matches the first operands).
- rst_i low at cycle 20 of a DIV -> immediately busy_o=0, hi_o=lo_o=0. After release, a new MULTU 6×7 -> LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Absolute value of a sign-extended two's-complement operand; callers truncate to their width
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? -x : x;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational multiply (shift-add) or divide (restoring shift-subtract) iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               op_is_div,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // acc is {upper, lower}: multiply shifts right after a conditional add, divide shifts left then trial-subtracts
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, operand};
        acc_next = op_is_div ? {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~diff[WIDTH]}
                             : {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO with busy/done handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt, prod;
    logic [WIDTH-1:0]     operand, a_in, b_in, quo, rem, res_hi, res_lo;
    logic                 is_div, neg_q, neg_r, dz, signed_op, is_div_op, accept;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .operand   (operand),
        .op_is_div (is_div),
        .acc_next  (acc_nxt)
    );

    // Decode the incoming request and form the magnitudes the iteration works on
    always_comb begin
        signed_op = !(op_i inside {OP_MULTU, OP_DIVU});
        is_div_op = op_i inside {OP_DIV, OP_DIVU};
        accept    = state_q == IDLE && start_i && !flush_i;
        a_in      = signed_op ? WIDTH'(abs_val(MAX_W'($signed(data1_i)))) : data1_i;
        b_in      = signed_op ? WIDTH'(abs_val(MAX_W'($signed(data2_i)))) : data2_i;
    end

    // Next state: flush always wins, RUN leaves after the last step, FIN lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = flush_i ? IDLE : (cnt == '0 ? FIN : RUN);
            default: state_d = IDLE;
        endcase
    end

    // Sign-corrected results; a zero divisor forces an all-ones quotient
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = is_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (dz ? '1 : (neg_q ? -quo : quo)) : prod[WIDTH-1:0];
    end

    // State, datapath and architectural HI/LO registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            operand    <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_o     <= state_d != IDLE;
            done_o     <= state_q == FIN && !flush_i;
            div_zero_o <= state_q == FIN && !flush_i && is_div && dz;
            if (state_q == IDLE) begin
                if (wr_hi_i) hi_o <= wr_data_i;
                if (wr_lo_i) lo_o <= wr_data_i;
                if (accept) begin
                    is_div  <= is_div_op;
                    operand <= is_div_op ? b_in : a_in;
                    acc     <= {{WIDTH{1'b0}}, (is_div_op ? a_in : b_in)};
                    neg_q   <= signed_op && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
                    neg_r   <= signed_op && is_div_op && data1_i[WIDTH-1];
                    dz      <= data2_i == '0;
                    cnt     <= CNT_W'(WIDTH - 1);
                end
            end else if (state_q == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt - 1'b1;
            end else if (state_q == FIN && !flush_i) begin
                hi_o <= res_hi;
                lo_o <= res_lo;
            end
        end
    end
endmodule
